nav_fsm_timed: RTL

Parametrised successor to the wall-follower navigation FSM, using a right-hand-rule maze policy. It takes multi-bit IR proximity readings (higher value = closer wall) and applies per-sensor hysteresis and decision debounce. Turns are timed, followed by a settle interval. Registered RPM setpoints, enables and directions drive the two downstream PID motor loops.

---
 rtl/nav_pkg.sv | 63 ++++++
 rtl/nav_fsm_timed_ir_hysteresis.sv | 48 ++++
 rtl/nav_fsm_timed.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared types and the state-to-drive decode for the timed maze navigator.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FORWARD     = 3'd1,
    TURN_LEFT   = 3'd2,
    TURN_RIGHT  = 3'd3,
    TURN_AROUND = 3'd4,
    SETTLE      = 3'd5
  } nav_state_t;

  // Setpoints travel at a fixed generous width; the top trims to RPM_W.
  localparam int unsigned SP_W = 32;

  typedef struct packed {
    logic [SP_W-1:0] rpm_left;
    logic [SP_W-1:0] rpm_right;
    logic            en_left;
    logic            en_right;
    logic            dir_left;
    logic            dir_right;
    logic            turning;
  } drive_t;

  // Motor bundle for a given navigation state (direction 1 = forward).
  function automatic drive_t decode_drive(
    input nav_state_t      st,
    input logic [SP_W-1:0] cruise_rpm,
    input logic [SP_W-1:0] fast_rpm,
    input logic [SP_W-1:0] slow_rpm,
    input logic [SP_W-1:0] spin_rpm
  );
    drive_t d;
    d = '0;
    case (st)
      IDLE: begin
        d = '0;
      end
      FORWARD, SETTLE: begin
        d = '{rpm_left: cruise_rpm, rpm_right: cruise_rpm, en_left: 1'b1, en_right: 1'b1,
              dir_left: 1'b1, dir_right: 1'b1, turning: 1'b0};
      end
      TURN_RIGHT: begin
        d = '{rpm_left: fast_rpm, rpm_right: slow_rpm, en_left: 1'b1, en_right: 1'b1,
              dir_left: 1'b1, dir_right: 1'b1, turning: 1'b1};
      end
      TURN_LEFT: begin
        d = '{rpm_left: slow_rpm, rpm_right: fast_rpm, en_left: 1'b1, en_right: 1'b1,
              dir_left: 1'b1, dir_right: 1'b1, turning: 1'b1};
      end
      TURN_AROUND: begin
        d = '{rpm_left: spin_rpm, rpm_right: spin_rpm, en_left: 1'b1, en_right: 1'b1,
              dir_left: 1'b1, dir_right: 1'b0, turning: 1'b1};
      end
      default: begin
        d = '0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nav_fsm_timed_ir_hysteresis.sv
// Per-sensor open/closed flag with a dead band between the two thresholds.
// `open` presents the flag as updated by the current sample, so decisions
// taken this cycle already see the new reading.
module ir_hysteresis
  import nav_pkg::*;
#(
  parameter int unsigned SENSOR_W      = 12,
  parameter int unsigned OPEN_THRESH   = 1000,
  parameter int unsigned CLOSED_THRESH = 1200
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                sample_valid,
  input  logic [SENSOR_W-1:0] reading,
  output logic                open
);

  logic open_r;
  logic open_s;

  // Next flag value: set below the open threshold, clear above the closed one, else hold.
  always_comb begin
    open_s = open_r;
    if (sample_valid) begin
      if (32'(reading) < OPEN_THRESH) begin
        open_s = 1'b1;
      end else if (32'(reading) > CLOSED_THRESH) begin
        open_s = 1'b0;
      end else begin
        open_s = open_r;
      end
    end else begin
      open_s = open_r;
    end
  end

  // Flag register; a closed wall is assumed out of reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      open_r <= 1'b0;
    end else begin
      open_r <= open_s;
    end
  end

  assign open = open_s;

endmodule

// File: rtl/nav_fsm_timed.sv
// Right-hand-rule maze navigator: hysteretic IR flags, debounced turn
// decisions, timed turns followed by a settle interval, registered drive.
module nav_fsm_timed
  import nav_pkg::*;
#(
  parameter int unsigned SENSOR_W           = 12,
  parameter int unsigned RPM_W              = 21,
  parameter int unsigned OPEN_THRESH        = 1000,
  parameter int unsigned CLOSED_THRESH      = 1200,
  parameter int unsigned DEBOUNCE_SAMPLES   = 3,
  parameter int unsigned TURN_CYCLES        = 25_000_000,
  parameter int unsigned TURN_AROUND_CYCLES = 50_000_000,
  parameter int unsigned SETTLE_CYCLES      = 10_000_000,
  parameter int unsigned CRUISE_RPM         = 100,
  parameter int unsigned TURN_FAST_RPM      = 100,
  parameter int unsigned TURN_SLOW_RPM      = 50,
  parameter int unsigned SPIN_RPM           = 100
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                run_en,
  input  logic                sample_valid,
  input  logic [SENSOR_W-1:0] right_ir,
  input  logic [SENSOR_W-1:0] left_ir,
  input  logic [SENSOR_W-1:0] forward_ir,
  output logic [RPM_W-1:0]    rpm_left_setpoint,
  output logic [RPM_W-1:0]    rpm_right_setpoint,
  output logic                left_motor_en,
  output logic                right_motor_en,
  output logic                left_motor_direction,
  output logic                right_motor_direction,
  output logic [2:0]          state_out,
  output logic                turning
);

  localparam int unsigned MAX_TURN = (TURN_CYCLES > TURN_AROUND_CYCLES) ? TURN_CYCLES : TURN_AROUND_CYCLES;
  localparam int unsigned MAX_CYC  = (MAX_TURN > SETTLE_CYCLES) ? MAX_TURN : SETTLE_CYCLES;
  localparam int unsigned TMR_W    = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);

  if (CLOSED_THRESH < OPEN_THRESH) begin : g_bad_thresh
    $error("CLOSED_THRESH must be >= OPEN_THRESH");
  end
  if (((64'(CRUISE_RPM) | 64'(TURN_FAST_RPM) | 64'(TURN_SLOW_RPM) | 64'(SPIN_RPM)) >> RPM_W) != 64'd0) begin : g_bad_rpm
    $error("setpoint constant does not fit in RPM_W");
  end

  logic       right_open_s;
  logic       left_open_s;
  logic       fwd_open_s;
  nav_state_t cand_s;
  nav_state_t state_r;
  nav_state_t next_state_s;
  nav_state_t prev_cand_r;
  nav_state_t prev_cand_next_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  drive_t           drive_s;

  ir_hysteresis #(.SENSOR_W(SENSOR_W), .OPEN_THRESH(OPEN_THRESH), .CLOSED_THRESH(CLOSED_THRESH)) u_hyst_right (
    .clk_in(clk_in), .reset_in(reset_in), .sample_valid(sample_valid), .reading(right_ir), .open(right_open_s));
  ir_hysteresis #(.SENSOR_W(SENSOR_W), .OPEN_THRESH(OPEN_THRESH), .CLOSED_THRESH(CLOSED_THRESH)) u_hyst_left (
    .clk_in(clk_in), .reset_in(reset_in), .sample_valid(sample_valid), .reading(left_ir), .open(left_open_s));
  ir_hysteresis #(.SENSOR_W(SENSOR_W), .OPEN_THRESH(OPEN_THRESH), .CLOSED_THRESH(CLOSED_THRESH)) u_hyst_fwd (
    .clk_in(clk_in), .reset_in(reset_in), .sample_valid(sample_valid), .reading(forward_ir), .open(fwd_open_s));

  // Right-hand rule: prefer right, then straight, then left, else reverse.
  always_comb begin
    cand_s = TURN_AROUND;
    if (right_open_s) begin
      cand_s = TURN_RIGHT;
    end else if (fwd_open_s) begin
      cand_s = FORWARD;
    end else if (left_open_s) begin
      cand_s = TURN_LEFT;
    end else begin
      cand_s = TURN_AROUND;
    end
  end

  // Next state, turn/settle timer and decision debounce.
  always_comb begin
    next_state_s     = state_r;
    timer_next_s     = timer_r;
    cnt_next_s       = cnt_r;
    prev_cand_next_s = prev_cand_r;
    cnt_inc_s        = CNT_W'(1);
    if (!run_en) begin
      next_state_s     = IDLE;
      timer_next_s     = TMR_W'(0);
      cnt_next_s       = CNT_W'(0);
      prev_cand_next_s = FORWARD;
    end else begin
      case (state_r)
        IDLE: begin
          next_state_s     = FORWARD;
          timer_next_s     = TMR_W'(0);
          cnt_next_s       = CNT_W'(0);
          prev_cand_next_s = FORWARD;
        end
        FORWARD: begin
          if (sample_valid) begin
            if (cand_s == FORWARD) begin
              cnt_next_s       = CNT_W'(0);
              prev_cand_next_s = FORWARD;
            end else begin
              if (cand_s == prev_cand_r) begin
                cnt_inc_s = cnt_r + CNT_W'(1);
              end else begin
                cnt_inc_s = CNT_W'(1);
              end
              if (32'(cnt_inc_s) >= DEBOUNCE_SAMPLES) begin
                next_state_s     = cand_s;
                cnt_next_s       = CNT_W'(0);
                prev_cand_next_s = FORWARD;
                if (cand_s == TURN_AROUND) begin
                  timer_next_s = TMR_W'(TURN_AROUND_CYCLES - 1);
                end else begin
                  timer_next_s = TMR_W'(TURN_CYCLES - 1);
                end
              end else begin
                cnt_next_s       = cnt_inc_s;
                prev_cand_next_s = cand_s;
              end
            end
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        TURN_LEFT, TURN_RIGHT, TURN_AROUND: begin
          if (timer_r == TMR_W'(0)) begin
            next_state_s = SETTLE;
            timer_next_s = TMR_W'(SETTLE_CYCLES - 1);
          end else begin
            timer_next_s = timer_r - TMR_W'(1);
          end
        end
        SETTLE: begin
          if (timer_r == TMR_W'(0)) begin
            next_state_s     = FORWARD;
            cnt_next_s       = CNT_W'(0);
            prev_cand_next_s = FORWARD;
          end else begin
            timer_next_s = timer_r - TMR_W'(1);
          end
        end
        default: begin
          next_state_s     = IDLE;
          timer_next_s     = TMR_W'(0);
          cnt_next_s       = CNT_W'(0);
          prev_cand_next_s = FORWARD;
        end
      endcase
    end
  end

  // Drive bundle decoded from the upcoming state so outputs move with state_out.
  always_comb begin
    drive_s = decode_drive(next_state_s, SP_W'(CRUISE_RPM), SP_W'(TURN_FAST_RPM),
                           SP_W'(TURN_SLOW_RPM), SP_W'(SPIN_RPM));
  end

  // State, timer, debounce history and registered motor outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r               <= IDLE;
      timer_r               <= TMR_W'(0);
      cnt_r                 <= CNT_W'(0);
      prev_cand_r           <= FORWARD;
      rpm_left_setpoint     <= RPM_W'(0);
      rpm_right_setpoint    <= RPM_W'(0);
      left_motor_en         <= 1'b0;
      right_motor_en        <= 1'b0;
      left_motor_direction  <= 1'b0;
      right_motor_direction <= 1'b0;
      state_out             <= 3'd0;
      turning               <= 1'b0;
    end else begin
      state_r               <= next_state_s;
      timer_r               <= timer_next_s;
      cnt_r                 <= cnt_next_s;
      prev_cand_r           <= prev_cand_next_s;
      rpm_left_setpoint     <= RPM_W'(drive_s.rpm_left);
      rpm_right_setpoint    <= RPM_W'(drive_s.rpm_right);
      left_motor_en         <= drive_s.en_left;
      right_motor_en        <= drive_s.en_right;
      left_motor_direction  <= drive_s.dir_left;
      right_motor_direction <= drive_s.dir_right;
      state_out             <= next_state_s;
      turning               <= drive_s.turning;
    end
  end

endmodule
